// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory bus plus boot-load port of the memory responder.
// Latency: none, wires only; timing is owned by the responder.
// Backpressure: load_ready gates the boot port; the CPU port has no stall.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  // CPU side
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;
  // boot loader side
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  boot_done;

  modport master (
    output we, addr, data, load_valid, load_data, load_last,
    input  out, load_ready, load_count, boot_done
  );

  modport slave (
    input  we, addr, data, load_valid, load_data, load_last,
    output out, load_ready, load_count, boot_done
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word store for the CPU, filled from a boot-load port before boot_done releases the CPU.
// Latency: read data registered, on out one cycle after the address; boot words written on their accept edge.
// Backpressure: load_ready is high throughout LOAD so no boot word stalls; CPU port never stalls.
// Optional: MEM_WRITE_THROUGH_EN also drives the written data onto out on a RUN write.
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_PTR   = ADDR_WIDTH'(LOAD_BASE);
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [CW-1:0]         load_count_q;
  logic                  load_ready_q;
  logic                  boot_done_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          load_fire;
  logic          load_done;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [CW-1:0] count_next;

  // A boot word is taken whenever one is offered in LOAD; load_ready is implied by the state.
  assign load_fire  = (state == LOAD) && bus.load_valid;
  assign count_next = load_count_q + 1'b1;
  // The load ends on the flagged word or once every location has been filled.
  assign load_done  = bus.load_last || (count_next == FULL_COUNT);
  // An undriven CPU (we is x/z) must neither read nor write, hence the case-equality tests.
  assign cpu_rd     = (state == RUN) && (bus.we === 1'b0);
  assign cpu_wr     = (state == RUN) && (bus.we === 1'b1) && !$isunknown(bus.addr);

  // Control FSM with registered handshake outputs and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      ptr          <= BASE_PTR;
      load_count_q <= '0;
      load_ready_q <= 1'b1;
      boot_done_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire) begin
            ptr          <= ptr + 1'b1;
            load_count_q <= count_next;
            if (load_done) begin
              state        <= RUN;
              load_ready_q <= 1'b0;
              boot_done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cpu_rd) begin
            out_q <= mem[bus.addr];
          end
`ifdef MEM_WRITE_THROUGH_EN
          else if (cpu_wr) begin
            out_q <= bus.data;
          end
`endif
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset so a mid-load reset keeps untouched words.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[ptr] <= bus.load_data;
    end else if (cpu_wr) begin
      mem[bus.addr] <= bus.data;
    end
  end

  assign bus.out        = out_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_count = load_count_q;
  assign bus.boot_done  = boot_done_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven, hand-sequenced and randomized checks of mem_responder.
// Latency: expects read data on out one edge after the address is presented.
// Backpressure: the loader is expected to accept every offered word while loading.
module tb_mem_responder;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;
  localparam int BASE  = 0;

`ifdef MEM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOAD_BASE (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_out;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: plain word array, the word count of the current load, and the expected out.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_out;
  int            model_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    model_mem[(BASE + model_count) % DEPTH] = d;
    model_count++;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we   = w;
    bus.addr = a;
    bus.data = d;
    tick();
    if (w) begin
      model_mem[a] = d;
      if (WT) model_out = d;
    end else begin
      model_out = model_mem[a];
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, " out"},        32'(bus.out), 0);
    check({tag, " boot_done"},  32'(bus.boot_done), 0);
    check({tag, " load_count"}, 32'(bus.load_count), 0);
    check({tag, " load_ready"}, 32'(bus.load_ready), 1);
    @(negedge clk);
    rst_n       = 1'b1;
    model_count = 0;
    model_out   = '0;
  endtask

  vec_t tbl [8];

  initial begin
    logic [DW-1:0] last_word;
    logic [DW-1:0] w4 [4];
    int            guard;

    // RUN-phase vectors following a load of 7100/8100/F000 at addresses 0..2.
    tbl[0] = '{1'b0, 6'd0, 16'h0000, 16'h7100};
    tbl[1] = '{1'b0, 6'd1, 16'h0000, 16'h8100};
    tbl[2] = '{1'b0, 6'd2, 16'h0000, 16'hF000};
    tbl[3] = '{1'b1, 6'd5, 16'h1234, WT ? 16'h1234 : 16'hF000};
    tbl[4] = '{1'b0, 6'd5, 16'h0000, 16'h1234};
    tbl[5] = '{1'b1, 6'd0, 16'hABCD, WT ? 16'hABCD : 16'h1234};
    tbl[6] = '{1'b0, 6'd0, 16'h0000, 16'hABCD};
    tbl[7] = '{1'b0, 6'd2, 16'h0000, 16'hF000};

    bus.we         = 1'b0;
    bus.addr       = '0;
    bus.data       = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    model_count    = 0;
    model_out      = '0;

    // Reset state.
    #12;
    check("rst out",        32'(bus.out), 0);
    check("rst load_ready", 32'(bus.load_ready), 1);
    check("rst load_count", 32'(bus.load_count), 0);
    check("rst boot_done",  32'(bus.boot_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-word load, last flagged on the third.
    load_word(16'h7100, 1'b0);
    check("A cnt1", 32'(bus.load_count), 1);
    check("A done1", 32'(bus.boot_done), 0);
    load_word(16'h8100, 1'b0);
    check("A cnt2", 32'(bus.load_count), 2);
    check("A done2", 32'(bus.boot_done), 0);
    load_word(16'hF000, 1'b1);
    check("A cnt3", 32'(bus.load_count), 3);
    check("A done3", 32'(bus.boot_done), 1);
    check("A ready3", 32'(bus.load_ready), 0);

    for (int i = 0; i < 8; i++) begin
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].data);
      check($sformatf("tbl[%0d] out", i), 32'(bus.out), 32'(tbl[i].exp_out));
    end

    // Undriven CPU for three cycles: out and memory unchanged.
    cpu_op(1'b0, 6'd5, 16'h0000);
    check("A rd5", 32'(bus.out), 32'h1234);
    bus.we   = 1'bx;
    bus.addr = 6'd5;
    bus.data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle%0d out", i), 32'(bus.out), 32'h1234);
    end
    cpu_op(1'b0, 6'd0, 16'h0000);
    check("post-idle rd0", 32'(bus.out), 32'hABCD);
    cpu_op(1'b0, 6'd5, 16'h0000);
    check("post-idle rd5", 32'(bus.out), 32'h1234);

    // Loader pushing during RUN must be ignored.
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hFFFF;
    bus.load_last  = 1'b1;
    cpu_op(1'b1, 6'd0, 16'h5A5A);
    cpu_op(1'b0, 6'd0, 16'h0000);
    check("run-load rd0", 32'(bus.out), 32'h5A5A);
    check("run-load cnt", 32'(bus.load_count), 3);
    check("run-load done", 32'(bus.boot_done), 1);

    // Gapped load of four words.
    async_reset("B");
    w4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        load_word(w4[i / 2], i == 6);
      end else begin
        bus.load_valid = 1'b0;
        tick();
      end
      check($sformatf("B cnt step%0d", i), 32'(bus.load_count), 32'(i / 2 + 1));
    end
    check("B done", 32'(bus.boot_done), 1);
    for (int a = 0; a < 6; a++) begin
      if (a != 4) begin
        cpu_op(1'b0, AW'(a), 16'h0000);
        check($sformatf("B rd%0d", a), 32'(bus.out), 32'(model_mem[a]));
      end
    end

    // Full-depth random-gapped load with no last flag, then random traffic.
    async_reset("C");
    guard = 0;
    last_word = '0;
    while (model_count < DEPTH && guard < 1000) begin
      guard++;
      if ($urandom_range(0, 2) != 0) begin
        last_word = DW'($urandom);
        load_word(last_word, 1'b0);
      end else begin
        bus.load_valid = 1'b0;
        tick();
      end
      check("C cnt", 32'(bus.load_count), 32'(model_count));
      check("C done", 32'(bus.boot_done), 32'(model_count == DEPTH));
    end
    check("C reached full", 32'(model_count), 32'(DEPTH));
    cpu_op(1'b0, 6'd63, 16'h0000);
    check("C rd63", 32'(bus.out), 32'(last_word));
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      cpu_op(1'($urandom), a, DW'($urandom));
      check("C rand out", 32'(bus.out), 32'(model_out));
    end
    check("C cnt frozen", 32'(bus.load_count), 32'(DEPTH));

    // Reset in the middle of a load, then a short reload.
    async_reset("D0");
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    check("D cnt2", 32'(bus.load_count), 2);
    async_reset("D1");
    load_word(16'hD1D1, 1'b0);
    load_word(16'hD2D2, 1'b1);
    check("D cnt", 32'(bus.load_count), 2);
    check("D done", 32'(bus.boot_done), 1);
    cpu_op(1'b0, 6'd0, 16'h0000);
    check("D rd0", 32'(bus.out), 32'hD1D1);
    cpu_op(1'b0, 6'd1, 16'h0000);
    check("D rd1", 32'(bus.out), 32'hD2D2);
    cpu_op(1'b0, 6'd2, 16'h0000);
    check("D rd2", 32'(bus.out), 32'(model_mem[2]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
